// File: rtl/bitmap_encoder_pkg.sv
// Shared types and constants for the bitmap index encoder.
//   bitmap_enc_state_t   : scan FSM states
//   BITMAP_ENC_N_DEFAULT : default bitmap width
package bitmap_encoder_pkg;

   localparam int unsigned BITMAP_ENC_N_DEFAULT = 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } bitmap_enc_state_t;

endpackage : bitmap_encoder_pkg

// File: rtl/priority_encoder.sv
// Combinational priority encoder over an N-bit vector.
//   vec    : input vector
//   index  : position of the highest-priority set bit (0 when none set)
//   found  : at least one bit set
//   single : exactly one bit set
// Priority is lowest bit first by default; defining
// BITMAP_ENCODER_MSB_FIRST_EN selects highest bit first.
module priority_encoder #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] index,
   output logic         found,
   output logic         single
);

   // Later loop iterations overwrite earlier ones, so the scan runs
   // from the lowest-priority end toward the highest-priority end.
   always_comb begin
      index = '0;
`ifdef BITMAP_ENCODER_MSB_FIRST_EN
      for (int i = 0; i < int'(N); i++) begin
         if (vec[i]) index = W'(i);
      end
`else
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (vec[i]) index = W'(i);
      end
`endif
   end

   assign found  = |vec;
   // Clearing the lowest set bit leaves zero only for a one-hot vector.
   assign single = found && ((vec & (vec - N'(1))) == '0);

endmodule : priority_encoder

// File: rtl/bitmap_index_encoder.sv
// Serializes an N-bit bitmap into the indices of its set bits, one per
// cycle, over valid/ready handshakes.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_bits: bitmap input handshake
//   out_valid/out_ready      : index output handshake
//   out_index, out_last      : current index, final index of the bitmap
//   done                     : one-cycle pulse after each bitmap (incl. zero)
// Emission order set by BITMAP_ENCODER_MSB_FIRST_EN (see priority_encoder).
module bitmap_index_encoder
   import bitmap_encoder_pkg::*;
#(
   parameter int unsigned N = BITMAP_ENC_N_DEFAULT,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_bits,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_index,
   output logic         out_last,
   output logic         done
);

   bitmap_enc_state_t state, state_next;
   logic [N-1:0]      pending, pending_next;
   logic              done_next;
   logic              found;
   logic              single;

   // Index and last flag decode straight from the pending register.
   priority_encoder #(
      .N (N),
      .W (W)
   ) u_penc (
      .vec    (pending),
      .index  (out_index),
      .found  (found),
      .single (single)
   );

   assign out_last = single;

   // State, pending bitmap and handshake flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pending   <= '0;
         done      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         pending   <= pending_next;
         done      <= done_next;
         in_ready  <= (state_next == S_IDLE);
         out_valid <= (state_next == S_SCAN);
      end
   end

   // Next-state: capture in idle, retire one index per handshake in scan.
   always_comb begin
      state_next   = state;
      pending_next = pending;
      done_next    = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               pending_next = in_bits;
               if (|in_bits) state_next = S_SCAN;
               else          done_next  = 1'b1;
            end
         end
         S_SCAN: begin
            if (out_ready && found) begin
               pending_next = pending & ~(N'(1) << out_index);
               if (single) begin
                  state_next = S_IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: begin
            state_next   = S_IDLE;
            pending_next = '0;
         end
      endcase
   end

endmodule : bitmap_index_encoder
